// File: rtl/pc_unit.sv
// Fetch-stage program counter: sequential/branch/JALR target selection,
// alignment trap redirect, halt/resume control and a retired-instruction counter.
module pc_unit #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int              IALIGN       = 4,
  parameter int              CNT_W        = 32
) (
  input  logic             clk,
  input  logic             areset,
  input  logic             load,
  input  logic [1:0]       pc_src,
  input  logic             compressed,
  input  logic [XLEN-1:0]  offset,
  input  logic [XLEN-1:0]  base,
  input  logic [XLEN-1:0]  trap_vec,
  input  logic             halt_req,
  input  logic             resume,
  output logic [XLEN-1:0]  pc,
  output logic [XLEN-1:0]  pc_prev,
  output logic             pc_valid,
  output logic             halted,
  output logic             misaligned,
  output logic [XLEN-1:0]  bad_addr,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [1:0] {BOOT, RUN, HALT, TRAP} state_t;

  state_t           state_q, state_d;
  logic [XLEN-1:0]  pc_q, pc_d;
  logic [XLEN-1:0]  pc_prev_q, pc_prev_d;
  logic [XLEN-1:0]  bad_addr_q, bad_addr_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             misaligned_q, misaligned_d;
  logic             pc_valid_q, pc_valid_d;
  logic             halted_q, halted_d;

  logic [XLEN-1:0]  seq_step;
  logic [XLEN-1:0]  target;
  logic             check_align;
  logic             target_bad;

  // Sequential targets are never alignment-checked; only redirects can trap.
  always_comb begin
    seq_step    = XLEN'(4);
    target      = '0;
    check_align = 1'b0;
    if (IALIGN == 2 && compressed) begin
      seq_step = XLEN'(2);
    end
    case (pc_src)
      2'b01: begin
        target      = pc_q + offset;
        check_align = 1'b1;
      end
      2'b10: begin
        target      = (base + offset) & ~XLEN'(1);
        check_align = 1'b1;
      end
      default: target = pc_q + seq_step;
    endcase
    if (IALIGN == 2) begin
      target_bad = check_align && target[0];
    end else begin
      target_bad = check_align && (target[1:0] != 2'b00);
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    pc_prev_d    = pc_prev_q;
    bad_addr_d   = bad_addr_q;
    retired_d    = retired_q;
    misaligned_d = 1'b0;
    case (state_q)
      BOOT: state_d = RUN;
      RUN: begin
        if (halt_req) begin
          state_d = HALT;
        end else if (load) begin
          pc_prev_d = pc_q;
          if (target_bad) begin
            pc_d         = trap_vec;
            bad_addr_d   = target;
            misaligned_d = 1'b1;
            state_d      = TRAP;
          end else begin
            pc_d      = target;
            retired_d = retired_q + CNT_W'(1);
          end
        end
      end
      TRAP: state_d = RUN;
      HALT: begin
        // A simultaneous halt request keeps the unit parked.
        if (!halt_req && resume) begin
          state_d = RUN;
        end
      end
      default: state_d = BOOT;
    endcase
    pc_valid_d = (state_d == RUN);
    halted_d   = (state_d == HALT);
  end

  always_ff @(posedge clk) begin
    if (areset) begin
      state_q      <= BOOT;
      pc_q         <= RESET_VECTOR;
      pc_prev_q    <= '0;
      bad_addr_q   <= '0;
      retired_q    <= '0;
      misaligned_q <= 1'b0;
      pc_valid_q   <= 1'b0;
      halted_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      pc_prev_q    <= pc_prev_d;
      bad_addr_q   <= bad_addr_d;
      retired_q    <= retired_d;
      misaligned_q <= misaligned_d;
      pc_valid_q   <= pc_valid_d;
      halted_q     <= halted_d;
    end
  end

  assign pc         = pc_q;
  assign pc_prev    = pc_prev_q;
  assign pc_valid   = pc_valid_q;
  assign halted     = halted_q;
  assign misaligned = misaligned_q;
  assign bad_addr   = bad_addr_q;
  assign retired    = retired_q;

endmodule

// File: tb/tb_pc_unit.sv
// Scoreboard bench for pc_unit: one IALIGN=4 instance and one IALIGN=2 instance
// with a 3-bit retired counter share the same stimulus.
module tb_pc_unit;

  localparam int ST_BOOT = 0;
  localparam int ST_RUN  = 1;
  localparam int ST_HALT = 2;
  localparam int ST_TRAP = 3;

  logic        clk;
  logic        areset;
  logic        load;
  logic [1:0]  pc_src;
  logic        compressed;
  logic [31:0] offset;
  logic [31:0] base;
  logic [31:0] trap_vec;
  logic        halt_req;
  logic        resume;

  logic [31:0] a_pc, a_prev, a_bad, a_ret;
  logic        a_valid, a_halted, a_mis;
  logic [31:0] b_pc, b_prev, b_bad;
  logic [2:0]  b_ret;
  logic        b_valid, b_halted, b_mis;

  pc_unit #(.XLEN(32), .RESET_VECTOR(32'h100), .IALIGN(4), .CNT_W(32)) dut_a (
    .clk(clk), .areset(areset), .load(load), .pc_src(pc_src), .compressed(compressed),
    .offset(offset), .base(base), .trap_vec(trap_vec), .halt_req(halt_req), .resume(resume),
    .pc(a_pc), .pc_prev(a_prev), .pc_valid(a_valid), .halted(a_halted),
    .misaligned(a_mis), .bad_addr(a_bad), .retired(a_ret)
  );

  pc_unit #(.XLEN(32), .RESET_VECTOR(32'h100), .IALIGN(2), .CNT_W(3)) dut_b (
    .clk(clk), .areset(areset), .load(load), .pc_src(pc_src), .compressed(compressed),
    .offset(offset), .base(base), .trap_vec(trap_vec), .halt_req(halt_req), .resume(resume),
    .pc(b_pc), .pc_prev(b_prev), .pc_valid(b_valid), .halted(b_halted),
    .misaligned(b_mis), .bad_addr(b_bad), .retired(b_ret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] prev;
    logic [31:0] bad;
    logic [63:0] ret;
    logic        valid;
    logic        halted;
    logic        mis;
  } exp_t;

  exp_t sb[$];

  int          total = 0;
  int          bad   = 0;

  int          m_state [2];
  logic [31:0] m_pc    [2];
  logic [31:0] m_prev  [2];
  logic [31:0] m_bad   [2];
  logic [63:0] m_ret   [2];
  logic        m_mis   [2];
  int          m_align [2] = '{4, 2};
  int          m_cw    [2] = '{32, 3};

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference behaviour of one unit for the inputs present at the coming edge.
  task automatic modelStep(input int i);
    logic [31:0] tgt;
    logic        redirect;
    logic        odd;
    m_mis[i] = 1'b0;
    if (areset) begin
      m_state[i] = ST_BOOT;
      m_pc[i]    = 32'h100;
      m_prev[i]  = '0;
      m_bad[i]   = '0;
      m_ret[i]   = '0;
    end else if (m_state[i] == ST_BOOT || m_state[i] == ST_TRAP) begin
      m_state[i] = ST_RUN;
    end else if (m_state[i] == ST_HALT) begin
      if (!halt_req && resume) m_state[i] = ST_RUN;
    end else if (halt_req) begin
      m_state[i] = ST_HALT;
    end else if (load) begin
      redirect = (pc_src == 2'b01) || (pc_src == 2'b10);
      if (pc_src == 2'b01)      tgt = m_pc[i] + offset;
      else if (pc_src == 2'b10) tgt = {base + offset} & 32'hFFFF_FFFE;
      else if (m_align[i] == 2 && compressed) tgt = m_pc[i] + 32'd2;
      else                      tgt = m_pc[i] + 32'd4;
      odd = (m_align[i] == 2) ? tgt[0] : (tgt[1] | tgt[0]);
      m_prev[i] = m_pc[i];
      if (redirect && odd) begin
        m_pc[i]    = trap_vec;
        m_bad[i]   = tgt;
        m_mis[i]   = 1'b1;
        m_state[i] = ST_TRAP;
      end else begin
        m_pc[i]  = tgt;
        m_ret[i] = (m_ret[i] + 64'd1) & ((64'd1 << m_cw[i]) - 64'd1);
      end
    end
  endtask

  task automatic checkUnit(input string who, input exp_t e, input logic [31:0] pc_o,
                           input logic [31:0] prev_o, input logic [31:0] bad_o,
                           input logic [63:0] ret_o, input logic valid_o,
                           input logic halted_o, input logic mis_o);
    checkOutput({who, ".pc"},     {32'd0, pc_o},   {32'd0, e.pc});
    checkOutput({who, ".prev"},   {32'd0, prev_o}, {32'd0, e.prev});
    checkOutput({who, ".bad"},    {32'd0, bad_o},  {32'd0, e.bad});
    checkOutput({who, ".ret"},    ret_o,           e.ret);
    checkOutput({who, ".valid"},  {63'd0, valid_o},  {63'd0, e.valid});
    checkOutput({who, ".halted"}, {63'd0, halted_o}, {63'd0, e.halted});
    checkOutput({who, ".mis"},    {63'd0, mis_o},    {63'd0, e.mis});
  endtask

  task automatic applyStimulus(input logic rst, input logic ld, input logic [1:0] src,
                               input logic cmp, input logic [31:0] off, input logic [31:0] bs,
                               input logic [31:0] tv, input logic hr, input logic rs);
    exp_t e;
    @(negedge clk);
    areset     = rst;
    load       = ld;
    pc_src     = src;
    compressed = cmp;
    offset     = off;
    base       = bs;
    trap_vec   = tv;
    halt_req   = hr;
    resume     = rs;
    for (int i = 0; i < 2; i++) begin
      modelStep(i);
      e.pc     = m_pc[i];
      e.prev   = m_prev[i];
      e.bad    = m_bad[i];
      e.ret    = m_ret[i];
      e.valid  = (m_state[i] == ST_RUN);
      e.halted = (m_state[i] == ST_HALT);
      e.mis    = m_mis[i];
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    if (sb.size() < 2) begin
      total++;
      bad++;
      $display("[TB] FAIL scoreboard underflow size=%0d exp=2", sb.size());
    end else begin
      e = sb.pop_front();
      checkUnit("a", e, a_pc, a_prev, a_bad, {32'd0, a_ret}, a_valid, a_halted, a_mis);
      e = sb.pop_front();
      checkUnit("b", e, b_pc, b_prev, b_bad, {61'd0, b_ret}, b_valid, b_halted, b_mis);
    end
  endtask

  initial begin
    areset = 1'b1; load = 1'b0; pc_src = 2'b00; compressed = 1'b0;
    offset = '0; base = '0; trap_vec = '0; halt_req = 1'b0; resume = 1'b0;

    $display("[TB] reset and boot");
    applyStimulus(1, 0, 2'b00, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 2'b00, 0, 0, 0, 0, 0, 0);
    checkOutput("rst_pc", {32'd0, a_pc}, 64'h100);
    checkOutput("rst_valid", {63'd0, a_valid}, 64'd0);
    applyStimulus(0, 1, 2'b00, 0, 0, 0, 0, 0, 0);
    checkOutput("boot_pc", {32'd0, a_pc}, 64'h100);
    checkOutput("boot_valid", {63'd0, a_valid}, 64'd1);

    $display("[TB] sequential wrap");
    applyStimulus(0, 1, 2'b01, 0, 32'hFFFF_FEFC, 0, 0, 0, 0);
    applyStimulus(0, 1, 2'b00, 0, 0, 0, 0, 0, 0);
    checkOutput("wrap_pc", {32'd0, a_pc}, 64'h0);
    checkOutput("wrap_prev", {32'd0, a_prev}, 64'hFFFF_FFFC);
    checkOutput("wrap_ret", {32'd0, a_ret}, 64'd2);
    applyStimulus(0, 0, 2'b01, 0, 32'h40, 0, 0, 0, 0);

    $display("[TB] branch and jalr");
    applyStimulus(0, 1, 2'b10, 0, 0, 32'h200, 0, 0, 0);
    applyStimulus(0, 1, 2'b01, 0, 32'hFFFF_FFF8, 0, 0, 0, 0);
    checkOutput("br_neg_pc", {32'd0, a_pc}, 64'h1F8);
    applyStimulus(0, 1, 2'b10, 0, 32'h10, 32'h1001, 0, 0, 0);
    checkOutput("jalr_pc", {32'd0, a_pc}, 64'h1010);
    checkOutput("jalr_mis", {63'd0, a_mis}, 64'd0);
    applyStimulus(0, 1, 2'b11, 0, 32'h8, 0, 0, 0, 0);

    $display("[TB] misaligned trap");
    applyStimulus(0, 1, 2'b10, 0, 0, 32'h40, 0, 0, 0);
    applyStimulus(0, 1, 2'b01, 0, 32'h6, 0, 32'h80, 0, 0);
    checkOutput("trap_pc", {32'd0, a_pc}, 64'h80);
    checkOutput("trap_bad", {32'd0, a_bad}, 64'h46);
    checkOutput("trap_mis", {63'd0, a_mis}, 64'd1);
    checkOutput("trap_valid", {63'd0, a_valid}, 64'd0);
    checkOutput("b_ret_wrap", {61'd0, b_ret}, 64'd0);
    applyStimulus(0, 1, 2'b01, 0, 32'h6, 0, 32'h80, 0, 0);
    checkOutput("post_trap_pc", {32'd0, a_pc}, 64'h80);
    checkOutput("post_trap_ret", {32'd0, a_ret}, 64'd7);

    $display("[TB] halt and resume");
    applyStimulus(0, 1, 2'b00, 0, 0, 0, 0, 1, 0);
    checkOutput("halt_halted", {63'd0, a_halted}, 64'd1);
    applyStimulus(0, 1, 2'b00, 0, 0, 0, 0, 1, 1);
    applyStimulus(0, 1, 2'b00, 0, 0, 0, 0, 0, 1);
    applyStimulus(0, 1, 2'b00, 0, 0, 0, 0, 0, 0);
    checkOutput("resume_pc", {32'd0, a_pc}, 64'h84);
    applyStimulus(0, 0, 2'b00, 0, 0, 0, 0, 1, 0);
    applyStimulus(1, 1, 2'b00, 0, 0, 0, 0, 1, 0);
    checkOutput("halt_rst_pc", {32'd0, a_pc}, 64'h100);

    $display("[TB] compressed");
    applyStimulus(0, 0, 2'b00, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 2'b10, 0, 0, 32'h10, 0, 0, 0);
    applyStimulus(0, 1, 2'b00, 1, 0, 0, 0, 0, 0);
    checkOutput("cmp_b_pc", {32'd0, b_pc}, 64'h12);
    checkOutput("cmp_a_pc", {32'd0, a_pc}, 64'h14);
    applyStimulus(0, 1, 2'b01, 0, 32'h3, 0, 32'h80, 0, 0);
    checkOutput("cmp_b_bad", {32'd0, b_bad}, 64'h15);
    applyStimulus(1, 1, 2'b01, 0, 32'h3, 0, 32'h80, 0, 0);
    applyStimulus(0, 1, 2'b00, 0, 0, 0, 0, 0, 0);

    $display("[TB] test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pc_unit.md
# pc_unit

Parametrised program-counter unit for the RISC-V core's fetch stage. It generates the fetch address each cycle from one of these sources:
- sequential increment (4, or 2 for compressed instructions);
- PC-relative branch/JAL target;
- register-indirect JALR target.

It checks target alignment and redirects to a trap vector on a misaligned target. A halt/resume state machine and a retired-instruction counter are included.

## Interface
- XLEN, 32: address/data width.
- RESET_VECTOR, 0: PC value after reset.
- IALIGN, 4: instruction alignment in bytes. Legal values are 2 (compressed enabled) or 4.
- CNT_W, 32: width of the retired-instruction counter.

- clk  in  1  clock; all state updates on the rising edge.
- areset  in  1  synchronous, active-high reset.
- load  in  1  advance enable; the PC updates only when high in RUN.
- pc_src  in  2  00 sequential, 01 branch relative, 10 JALR, 11 treated as sequential.
- compressed  in  1  current instruction is 16-bit. Honoured only when IALIGN=2.
- offset  in  XLEN  signed immediate for branch/JALR.
- base  in  XLEN  rs1 value for JALR.
- trap_vec  in  XLEN  redirect address on a misaligned target.
- halt_req  in  1  request to enter HALT.
- resume  in  1  request to leave HALT.
- pc  out  XLEN  current fetch address.
- pc_prev  out  XLEN  PC of the last instruction advanced past.
- pc_valid  out  1  pc is a valid fetch address this cycle.
- halted  out  1  high while in HALT.
- misaligned  out  1  one-cycle pulse when a misaligned target is detected.
- bad_addr  out  XLEN  offending target, held until the next misalignment or reset.
- retired  out  CNT_W  count of accepted advances.

## Operation
- FSM states: BOOT, RUN, HALT, TRAP.
- **Reset** (areset high at an edge): pc=RESET_VECTOR, pc_prev=0, bad_addr=0, retired=0, misaligned=0, state=BOOT. Reset overrides every other input.
- **BOOT**: pc_valid=0. Unconditionally goes to RUN next cycle; load is ignored.
- **RUN**: pc_valid=1. Priority order:
  - halt_req: go to HALT, no PC update.
  - else load: compute the target (rules below).
    - Aligned target: pc<=target, pc_prev<=pc, retired+=1.
    - Misaligned target: pc<=trap_vec, pc_prev<=pc, bad_addr<=target, misaligned=1 for one cycle, retired unchanged, go to TRAP.
  - else: hold.
- **TRAP**: pc_valid=0 for exactly one cycle, then RUN. Inputs are ignored.
- **HALT**: pc_valid=0, halted=1, pc held, load ignored.
  - resume with halt_req low: go to RUN.
  - halt_req high: stay in HALT (halt wins over a simultaneous resume).
- **Target computation** (all arithmetic modulo 2^XLEN; wrap is silent):
  - Sequential: pc+4, or pc+2 when IALIGN=2 and compressed=1.
  - Branch: pc+offset, with offset sign-extended.
  - JALR: (base+offset) with bit 0 forced to 0.
- **Misaligned** means target[1:0]!=0 when IALIGN=4, or target[0]!=0 when IALIGN=2. Sequential targets are never checked. A trap_vec value is not checked.
- retired wraps to 0 after its maximum value.

## Timing
- pc, pc_prev, pc_valid, halted, bad_addr and retired are registered; they update one cycle after the qualifying edge.
- misaligned asserts in the cycle after detection, i.e. concurrent with TRAP.
- Target computation is combinational from pc and the inputs in the same cycle. Branch/JALR redirect latency is 1 cycle.
- Throughput is one advance per cycle while in RUN with load held high.
- Reset asserted mid-HALT or mid-TRAP returns to BOOT on the next edge. No pending misaligned pulse survives.
- Fixed latencies after reset deassertion: pc_valid is first high 1 cycle later (BOOT→RUN). A HALT→RUN transition takes 1 cycle after resume is sampled.

## Test plan
- **Reset/boot**: RESET_VECTOR=0x100, assert areset for 2 cycles, then release → pc=0x100, pc_valid=0 for 1 cycle then 1; retired=0.
- **Sequential wrap**: pc=0xFFFFFFFC, pc_src=00, load=1 → pc=0x0, pc_prev=0xFFFFFFFC, retired incremented.
- **Branch and JALR**: pc=0x200, branch offset=-8 → pc=0x1F8. Then JALR with base=0x1001, offset=0x10 → pc=0x1010. No misaligned pulse in either case.
- **Misaligned trap**: IALIGN=4, pc=0x40, branch offset=0x6, trap_vec=0x80 → pc=0x80, bad_addr=0x46, misaligned pulses 1 cycle, pc_valid=0 for 1 cycle, retired unchanged.
- **Halt/resume**:
  - halt_req and load high together → PC unchanged, halted=1.
  - resume with halt_req still high → stays halted.
  - resume alone → RUN next cycle.
  - areset during HALT → BOOT with pc=RESET_VECTOR.
- **Compressed**: IALIGN=2, pc=0x10, compressed=1 → pc=0x12. Then branch offset=0x3 → trap with bad_addr=0x15. With IALIGN=4, compressed=1 → pc advances by 4.
